lcd_init_sequencer: RTL and testbench



---
 rtl/lcd_pkg.sv | 53 +++++
 rtl/lcd_init_sequencer_if.sv | 11 +
 rtl/lcd_delay_timer.sv | 25 ++
 rtl/lcd_init_sequencer.sv | 179 +++++++++++++++++
 tb/tb_lcd_init_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 init sequencer.
// Build option: LCD_INIT_CLEAR_EN appends a clear-display command to the init list.
package lcd_pkg;

    typedef enum logic [2:0] {
        S_PWR_WAIT,
        S_INIT_NIB,
        S_INIT_WAIT,
        S_CMD,
        S_CMD_GAP,
        S_IDLE,
        S_WRITE,
        S_POST
    } lcdState_e;

    localparam int TIMER_W = 20;

    localparam logic [1:0] LCD_MODE_NIBBLE = 2'd0;
    localparam logic [1:0] LCD_MODE_BYTE   = 2'd1;

    localparam logic [7:0] LCD_CMD_FUNCSET = 8'h28;
    localparam logic [7:0] LCD_CMD_ENTRY   = 8'h06;
    localparam logic [7:0] LCD_CMD_DISPON  = 8'h0C;
    localparam logic [7:0] LCD_CMD_CLEAR   = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME    = 8'h02;

`ifdef LCD_INIT_CLEAR_EN
    localparam logic [1:0] CMD_LAST = 2'd3;
`else
    localparam logic [1:0] CMD_LAST = 2'd2;
`endif

    localparam logic [1:0] NIB_LAST = 2'd3;

    // Three 0x3 nibbles force 8-bit mode from any state, then 0x2 drops to 4-bit mode.
    function automatic logic [3:0] initNibble(input logic [1:0] idx);
        return (idx == NIB_LAST) ? 4'h2 : 4'h3;
    endfunction

    function automatic logic [7:0] initCmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return LCD_CMD_FUNCSET;
            2'd1:    return LCD_CMD_ENTRY;
            2'd2:    return LCD_CMD_DISPON;
            default: return LCD_CMD_CLEAR;
        endcase
    endfunction

    function automatic logic needsClearWait(input logic rs, input logic [7:0] value);
        return !rs && ((value == LCD_CMD_CLEAR) || (value == LCD_CMD_HOME));
    endfunction

endpackage

// File: rtl/lcd_init_sequencer_if.sv
// Host request channel of the LCD init sequencer.
interface lcd_init_sequencer_if;
    logic       iReq;
    logic       iRS;
    logic [7:0] iByte;
    logic       oAck;
    logic       oReady;

    modport master (output iReq, iRS, iByte, input oAck, oReady);
    modport slave  (input iReq, iRS, iByte, output oAck, oReady);
endinterface

// File: rtl/lcd_delay_timer.sv
// Saturating delay timer: clears on request, counts up, flags when the limit is reached.
module lcd_delay_timer
    import lcd_pkg::*;
(
    input  logic               Clock,
    input  logic               Reset,
    input  logic               clear,
    input  logic [TIMER_W-1:0] limit,
    output logic               expired
);

    logic [TIMER_W-1:0] count;

    // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
    always_ff @(posedge Clock) begin
        if (Reset || clear) begin
            count <= '0;
        end else if (count != '1) begin
            count <= count + TIMER_W'(1);
        end
    end

    assign expired = (count >= limit);

endmodule

// File: rtl/lcd_init_sequencer.sv
// HD44780 power-up sequencer and host write arbiter in front of the 4-bit LCD writer.
// Build option: LCD_INIT_CLEAR_EN (see lcd_pkg) adds a clear command to the init list.
module lcd_init_sequencer
    import lcd_pkg::*;
#(
    parameter int P_WAIT_PWRUP = 750000,
    parameter int P_WAIT_4MS   = 205000,
    parameter int P_WAIT_100US = 5000,
    parameter int P_WAIT_CLEAR = 82000
) (
    input  logic                 Clock,
    input  logic                 Reset,
    lcd_init_sequencer_if.slave  host,
    output logic                 oLCD_RS,
    output logic                 oLCD_RW,
    output logic                 oWriter_Run,
    output logic [1:0]           oWriter_Mode,
    output logic [3:0]           oWriter_Nibble,
    output logic [7:0]           oWriter_Byte,
    input  logic                 iWriter_Done
);

    localparam logic [TIMER_W-1:0] LIM_PWRUP = TIMER_W'(P_WAIT_PWRUP);
    localparam logic [TIMER_W-1:0] LIM_4MS   = TIMER_W'(P_WAIT_4MS);
    localparam logic [TIMER_W-1:0] LIM_100US = TIMER_W'(P_WAIT_100US);
    localparam logic [TIMER_W-1:0] LIM_CLEAR = TIMER_W'(P_WAIT_CLEAR);

    lcdState_e          state, stateNext;
    logic [1:0]         nibIdx, nibIdxNext;
    logic [1:0]         cmdIdx, cmdIdxNext;
    logic               reqRs, reqRsNext;
    logic [7:0]         reqByte, reqByteNext;
    logic               ackNext, readyNext, runNext, rsNext;
    logic [1:0]         modeNext;
    logic [3:0]         nibbleNext;
    logic [7:0]         byteNext;
    logic [TIMER_W-1:0] timerLimit;
    logic               timerExpired;
    logic               timerClear;
    logic               doneSeen;

    // A done pulse only counts while a write is actually in flight.
    assign doneSeen   = iWriter_Done && oWriter_Run;
    assign timerClear = (stateNext != state);
    assign oLCD_RW    = 1'b0;

    lcd_delay_timer u_timer (
        .Clock   (Clock),
        .Reset   (Reset),
        .clear   (timerClear),
        .limit   (timerLimit),
        .expired (timerExpired)
    );

    // NOTE: every always_comb output is defaulted first so no path can infer a latch.
    always_comb begin
        stateNext   = state;
        nibIdxNext  = nibIdx;
        cmdIdxNext  = cmdIdx;
        reqRsNext   = reqRs;
        reqByteNext = reqByte;
        timerLimit  = '0;

        case (state)
            S_PWR_WAIT: begin
                timerLimit = LIM_PWRUP;
                if (timerExpired) stateNext = S_INIT_NIB;
            end
            S_INIT_NIB: begin
                if (doneSeen) stateNext = S_INIT_WAIT;
            end
            S_INIT_WAIT: begin
                timerLimit = (nibIdx == 2'd0) ? LIM_4MS : LIM_100US;
                if (timerExpired) begin
                    nibIdxNext = nibIdx + 2'd1;
                    stateNext  = (nibIdx == NIB_LAST) ? S_CMD : S_INIT_NIB;
                end
            end
            S_CMD: begin
                if (doneSeen) stateNext = S_CMD_GAP;
            end
            S_CMD_GAP: begin
                timerLimit = needsClearWait(1'b0, initCmd(cmdIdx)) ? LIM_CLEAR : '0;
                if (timerExpired) begin
                    if (cmdIdx == CMD_LAST) begin
                        stateNext = S_IDLE;
                    end else begin
                        cmdIdxNext = cmdIdx + 2'd1;
                        stateNext  = S_CMD;
                    end
                end
            end
            S_IDLE: begin
                if (host.iReq) begin
                    reqRsNext   = host.iRS;
                    reqByteNext = host.iByte;
                    stateNext   = S_WRITE;
                end
            end
            S_WRITE: begin
                if (doneSeen) stateNext = S_POST;
            end
            S_POST: begin
                timerLimit = needsClearWait(reqRs, reqByte) ? LIM_CLEAR : '0;
                if (timerExpired) stateNext = S_IDLE;
            end
            default: stateNext = S_PWR_WAIT;
        endcase
    end

    // Run is held low on the entry cycle of a write state, so data settles before it rises
    // and a host write starts one cycle after the ack.
    always_comb begin
        ackNext    = (state == S_IDLE) && (stateNext == S_WRITE);
        readyNext  = (stateNext == S_IDLE);
        runNext    = 1'b0;
        rsNext     = oLCD_RS;
        modeNext   = oWriter_Mode;
        nibbleNext = oWriter_Nibble;
        byteNext   = oWriter_Byte;

        if (stateNext == state) begin
            case (state)
                S_INIT_NIB, S_CMD, S_WRITE: runNext = 1'b1;
                default:                    runNext = 1'b0;
            endcase
        end else begin
            case (stateNext)
                S_INIT_NIB: begin
                    modeNext   = LCD_MODE_NIBBLE;
                    rsNext     = 1'b0;
                    nibbleNext = initNibble(nibIdxNext);
                end
                S_CMD: begin
                    modeNext = LCD_MODE_BYTE;
                    rsNext   = 1'b0;
                    byteNext = initCmd(cmdIdxNext);
                end
                S_WRITE: begin
                    modeNext = LCD_MODE_BYTE;
                    rsNext   = host.iRS;
                    byteNext = host.iByte;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state          <= S_PWR_WAIT;
            nibIdx         <= '0;
            cmdIdx         <= '0;
            reqRs          <= 1'b0;
            reqByte        <= '0;
            host.oAck      <= 1'b0;
            host.oReady    <= 1'b0;
            oLCD_RS        <= 1'b0;
            oWriter_Run    <= 1'b0;
            oWriter_Mode   <= LCD_MODE_NIBBLE;
            oWriter_Nibble <= '0;
            oWriter_Byte   <= '0;
        end else begin
            state          <= stateNext;
            nibIdx         <= nibIdxNext;
            cmdIdx         <= cmdIdxNext;
            reqRs          <= reqRsNext;
            reqByte        <= reqByteNext;
            host.oAck      <= ackNext;
            host.oReady    <= readyNext;
            oLCD_RS        <= rsNext;
            oWriter_Run    <= runNext;
            oWriter_Mode   <= modeNext;
            oWriter_Nibble <= nibbleNext;
            oWriter_Byte   <= byteNext;
        end
    end

endmodule

// File: tb/tb_lcd_init_sequencer.sv
// Directed bench for lcd_init_sequencer with a writer model that answers done 3 cycles after Run.
module tb_lcd_init_sequencer;

    logic       Clock;
    logic       Reset;
    logic       oLCD_RS, oLCD_RW, oWriter_Run;
    logic [1:0] oWriter_Mode;
    logic [3:0] oWriter_Nibble;
    logic [7:0] oWriter_Byte;
    logic       iWriter_Done;
    logic       modelDone;
    logic       spuriousDone;

    lcd_init_sequencer_if hostIf ();

    lcd_init_sequencer #(
        .P_WAIT_PWRUP (20),
        .P_WAIT_4MS   (10),
        .P_WAIT_100US (5),
        .P_WAIT_CLEAR (8)
    ) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .host           (hostIf),
        .oLCD_RS        (oLCD_RS),
        .oLCD_RW        (oLCD_RW),
        .oWriter_Run    (oWriter_Run),
        .oWriter_Mode   (oWriter_Mode),
        .oWriter_Nibble (oWriter_Nibble),
        .oWriter_Byte   (oWriter_Byte),
        .iWriter_Done   (iWriter_Done)
    );

    assign iWriter_Done = modelDone | spuriousDone;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

`ifdef LCD_INIT_CLEAR_EN
    localparam int N_CMD = 4;
`else
    localparam int N_CMD = 3;
`endif
    localparam int N_INIT = 4 + N_CMD;

    typedef struct {
        logic [1:0] mode;
        logic       rs;
        logic [3:0] nib;
        logic [7:0] data;
        int         rise;
        int         fall;
    } wr_t;

    wr_t wrLog[$];
    int  cyc = 0;
    int  runCycles = 0;
    bit  runPrev = 0, readyPrev = 0;
    int  stableErr = 0, badMode = 0;
    int  ackCount = 0, ackNoReady = 0, lastAckCyc = 0;
    int  readyRiseCyc = 0, releaseCyc = 0;
    int  checkCount = 0, passCount = 0;

    always @(posedge Clock) cyc <= cyc + 1;

    // Monitor plus writer model, evaluated away from the active edge.
    always @(negedge Clock) begin
        if (oWriter_Run && !runPrev)
            wrLog.push_back('{oWriter_Mode, oLCD_RS, oWriter_Nibble, oWriter_Byte, cyc, 0});
        if (oWriter_Run && runPrev && wrLog.size() > 0) begin
            if (oWriter_Mode != wrLog[wrLog.size()-1].mode || oLCD_RS != wrLog[wrLog.size()-1].rs ||
                oWriter_Nibble != wrLog[wrLog.size()-1].nib || oWriter_Byte != wrLog[wrLog.size()-1].data)
                stableErr++;
        end
        if (!oWriter_Run && runPrev && wrLog.size() > 0) wrLog[wrLog.size()-1].fall = cyc;
        if (oWriter_Mode == 2'd2) badMode++;
        if (hostIf.oAck) begin
            ackCount++;
            lastAckCyc = cyc;
            if (!readyPrev) ackNoReady++;
        end
        if (hostIf.oReady && !readyPrev) readyRiseCyc = cyc;
        runPrev   = oWriter_Run;
        readyPrev = hostIf.oReady;
        if (oWriter_Run) begin
            runCycles++;
            modelDone = (runCycles == 3);
        end else begin
            runCycles = 0;
            modelDone = 1'b0;
        end
    end

    task automatic tick();
        @(negedge Clock);
        #1;
    endtask

    task automatic waitReady(input int bound, output bit ok);
        int k;
        k = 0;
        while (!hostIf.oReady && k < bound) begin
            tick();
            k++;
        end
        ok = hostIf.oReady;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        hostIf.iReq = 1'b0; hostIf.iRS = 1'b0; hostIf.iByte = 8'h00;
        modelDone = 1'b0; spuriousDone = 1'b0;
        repeat (3) tick();
        checkCount++;
        if ({hostIf.oAck, hostIf.oReady, oLCD_RS, oLCD_RW, oWriter_Run} !== 5'b0)
            $display("FAIL reset_ctrl: ack/ready/rs/rw/run got %b want 00000",
                     {hostIf.oAck, hostIf.oReady, oLCD_RS, oLCD_RW, oWriter_Run});
        else passCount++;
        checkCount++;
        if ({oWriter_Mode, oWriter_Nibble, oWriter_Byte} !== 14'h0)
            $display("FAIL reset_data: mode/nibble/byte got %h want 0",
                     {oWriter_Mode, oWriter_Nibble, oWriter_Byte});
        else passCount++;
    endtask

    task automatic test_init();
        bit ok;
        logic [10:0] expv [N_INIT];
        logic [10:0] got;
        int gap;
        int minGap [4] = '{20, 10, 5, 5};
        expv[0] = {2'd0, 1'b0, 8'h03};
        expv[1] = {2'd0, 1'b0, 8'h03};
        expv[2] = {2'd0, 1'b0, 8'h03};
        expv[3] = {2'd0, 1'b0, 8'h02};
        expv[4] = {2'd1, 1'b0, 8'h28};
        expv[5] = {2'd1, 1'b0, 8'h06};
        expv[6] = {2'd1, 1'b0, 8'h0C};
`ifdef LCD_INIT_CLEAR_EN
        expv[7] = {2'd1, 1'b0, 8'h01};
`endif
        wrLog.delete();
        Reset = 1'b0;
        releaseCyc = cyc;
        waitReady(3000, ok);
        checkCount++;
        if (!ok) $display("FAIL init_ready: oReady got 0 want 1 within 3000 cycles");
        else passCount++;
        checkCount++;
        if (wrLog.size() != N_INIT) $display("FAIL init_count: writes got %0d want %0d", wrLog.size(), N_INIT);
        else passCount++;
        for (int i = 0; i < N_INIT && i < wrLog.size(); i++) begin
            got = {wrLog[i].mode, wrLog[i].rs, (wrLog[i].mode == 2'd0) ? {4'h0, wrLog[i].nib} : wrLog[i].data};
            checkCount++;
            if (got !== expv[i]) $display("FAIL init_write%0d: mode/rs/value got %h want %h", i, got, expv[i]);
            else passCount++;
        end
        for (int i = 0; i < 4 && i < wrLog.size(); i++) begin
            gap = (i == 0) ? wrLog[0].rise - releaseCyc : wrLog[i].rise - wrLog[i-1].fall;
            if (i == 3 && wrLog.size() > 4) gap = wrLog[4].rise - wrLog[3].fall;
            checkCount++;
            if (gap < minGap[i]) $display("FAIL init_gap%0d: gap got %0d want >= %0d", i, gap, minGap[i]);
            else passCount++;
        end
        if (wrLog.size() == N_INIT) begin
            gap = readyRiseCyc - wrLog[N_INIT-1].fall;
            checkCount++;
`ifdef LCD_INIT_CLEAR_EN
            if (gap < 8) $display("FAIL init_clear_wait: ready gap got %0d want >= 8", gap);
`else
            if (gap > 2) $display("FAIL init_no_clear_wait: ready gap got %0d want <= 2", gap);
`endif
            else passCount++;
        end
        checkCount++;
        if (stableErr != 0 || badMode != 0 || ackCount != 0)
            $display("FAIL init_hygiene: unstable %0d bad-mode %0d acks %0d want 0 0 0", stableErr, badMode, ackCount);
        else passCount++;
    endtask

    task automatic test_req_during_init();
        bit ok;
        int k;
        Reset = 1'b1;
        hostIf.iReq = 1'b1; hostIf.iRS = 1'b1; hostIf.iByte = 8'h41;
        repeat (2) tick();
        checkCount++;
        if (hostIf.oAck !== 1'b0) $display("FAIL req_vs_reset: oAck got %b want 0", hostIf.oAck);
        else passCount++;
        wrLog.delete();
        ackCount = 0; ackNoReady = 0;
        Reset = 1'b0;
        k = 0;
        while (!hostIf.oAck && k < 3000) begin
            tick();
            k++;
        end
        checkCount++;
        if (!hostIf.oAck) $display("FAIL req_ack: oAck got 0 want 1 within 3000 cycles");
        else passCount++;
        hostIf.iReq = 1'b0;
        checkCount++;
        if (ackNoReady != 0 || wrLog.size() != N_INIT)
            $display("FAIL req_wait_init: early acks %0d, writes before ack %0d want 0, %0d", ackNoReady, wrLog.size(), N_INIT);
        else passCount++;
        waitReady(200, ok);
        checkCount++;
        if (!ok || wrLog.size() != N_INIT + 1)
            $display("FAIL req_write: ready %b writes %0d want 1, %0d", ok, wrLog.size(), N_INIT + 1);
        else passCount++;
        if (wrLog.size() == N_INIT + 1) begin
            checkCount++;
            if ({wrLog[N_INIT].mode, wrLog[N_INIT].rs, wrLog[N_INIT].data} !== {2'd1, 1'b1, 8'h41})
                $display("FAIL req_data: mode/rs/byte got %h want 341",
                         {wrLog[N_INIT].mode, wrLog[N_INIT].rs, wrLog[N_INIT].data});
            else passCount++;
            checkCount++;
            if (wrLog[N_INIT].rise != lastAckCyc + 1)
                $display("FAIL req_run_timing: run rise cycle got %0d want %0d", wrLog[N_INIT].rise, lastAckCyc + 1);
            else passCount++;
        end
        checkCount++;
        if (ackCount != 1) $display("FAIL req_ack_count: acks got %0d want 1", ackCount);
        else passCount++;
    endtask

    task automatic doRequest(input logic rs, input logic [7:0] value, output int gap);
        bit ok;
        int k;
        hostIf.iRS = rs; hostIf.iByte = value; hostIf.iReq = 1'b1;
        k = 0;
        while (!hostIf.oAck && k < 100) begin
            tick();
            k++;
        end
        hostIf.iReq = 1'b0;
        tick();
        waitReady(200, ok);
        gap = ok ? readyRiseCyc - wrLog[wrLog.size()-1].fall : -1;
    endtask

    task automatic test_post_wait();
        int gap;
        doRequest(1'b0, 8'h01, gap);
        checkCount++;
        if (gap < 8 || wrLog[wrLog.size()-1].data !== 8'h01)
            $display("FAIL post_clear: ready gap %0d byte %h want >= 8, 01", gap, wrLog[wrLog.size()-1].data);
        else passCount++;
        doRequest(1'b0, 8'h80, gap);
        checkCount++;
        if (gap < 0 || gap > 2 || wrLog[wrLog.size()-1].data !== 8'h80)
            $display("FAIL post_plain: ready gap %0d byte %h want 1..2, 80", gap, wrLog[wrLog.size()-1].data);
        else passCount++;
    endtask

    task automatic test_spurious_done();
        int acks, writes;
        acks = ackCount;
        writes = wrLog.size();
        spuriousDone = 1'b1;
        tick();
        spuriousDone = 1'b0;
        repeat (3) tick();
        checkCount++;
        if (hostIf.oReady !== 1'b1 || oWriter_Run !== 1'b0 || ackCount != acks || wrLog.size() != writes)
            $display("FAIL spurious_done: ready %b run %b acks +%0d writes +%0d want 1 0 +0 +0",
                     hostIf.oReady, oWriter_Run, ackCount - acks, wrLog.size() - writes);
        else passCount++;
    endtask

    task automatic test_reset_mid_cmd();
        int k;
        Reset = 1'b1;
        repeat (2) tick();
        Reset = 1'b0;
        k = 0;
        while (!(oWriter_Run && oWriter_Mode == 2'd1 && oWriter_Byte == 8'h06) && k < 3000) begin
            tick();
            k++;
        end
        checkCount++;
        if (!oWriter_Run) $display("FAIL mid_reach_cmd: run on byte 06 got 0 want 1 within 3000 cycles");
        else passCount++;
        Reset = 1'b1;
        tick();
        checkCount++;
        if ({oWriter_Run, hostIf.oReady, hostIf.oAck, oLCD_RS, oWriter_Mode, oWriter_Nibble, oWriter_Byte} !== 18'h0)
            $display("FAIL mid_reset_outputs: got %h want 0",
                     {oWriter_Run, hostIf.oReady, hostIf.oAck, oLCD_RS, oWriter_Mode, oWriter_Nibble, oWriter_Byte});
        else passCount++;
        wrLog.delete();
        Reset = 1'b0;
        k = 0;
        while (wrLog.size() == 0 && k < 200) begin
            tick();
            k++;
        end
        checkCount++;
        if (wrLog.size() == 0) $display("FAIL mid_restart: no write within 200 cycles, want nibble 3");
        else if ({wrLog[0].mode, wrLog[0].nib} !== {2'd0, 4'h3})
            $display("FAIL mid_restart: mode/nibble got %h want 03", {wrLog[0].mode, wrLog[0].nib});
        else passCount++;
    endtask

    initial begin
        test_reset();
        test_init();
        test_req_during_init();
        test_post_wait();
        test_spurious_done();
        test_reset_mid_cmd();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
